// File: rtl/ysyx_23060203_idu_stage.sv
// RV32I/E decode stage, valid/ready both sides, 1-cycle latency; stalls upstream when EXU holds the output.
// YSYX_23060203_IDU_SKID_EN adds a one-entry skid buffer so in_ready comes straight from a flop.
module ysyx_23060203_idu_stage #(
  parameter int NR_REG = 32,
  localparam int RA_W = $clog2(NR_REG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [31:0]     in_pc,
  output logic [RA_W-1:0] reg_raddr1,
  output logic [RA_W-1:0] reg_raddr2,
  input  logic [31:0]     reg_rdata1,
  input  logic [31:0]     reg_rdata2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [4:0]      out_opcode,
  output logic [2:0]      out_funct,
  output logic [4:0]      out_rd,
  output logic [11:0]     out_csr,
  output logic [31:0]     out_src1,
  output logic [31:0]     out_src2,
  output logic [31:0]     out_imm,
  output logic [31:0]     out_alu_a,
  output logic [31:0]     out_alu_b,
  output logic [2:0]      out_alu_funct,
  output logic            out_alu_funcs,
  output logic            out_illegal
);

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_CALRI  = 5'b00100;
  localparam logic [4:0] OP_CALRR  = 5'b01100;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic [2:0]  funct;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_funct;
    logic        alu_funcs;
    logic        illegal;
  } dec_t;

  dec_t        dec;
  dec_t        out_q, out_d;
  logic        out_vld_q, out_vld_d;
  logic        accept;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        op_known, use_rd, use_rs1, use_rs2, bad_reg;

  assign reg_raddr1 = in_inst[15 +: RA_W];
  assign reg_raddr2 = in_inst[20 +: RA_W];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.opcode = in_inst[6:2];
    dec.funct  = in_inst[14:12];
    dec.rd     = in_inst[11:7];
    dec.csr    = in_inst[31:20];
    dec.src1   = reg_rdata1;
    dec.src2   = reg_rdata2;
    dec.alu_b  = 32'd4;
    op_known   = 1'b1;
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    bad_reg    = 1'b0;
    case (in_inst[6:2])
      OP_LUI: begin
        dec.imm = imm_u; dec.alu_b = imm_u; use_rd = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm = imm_u; dec.alu_a = in_pc; dec.alu_b = imm_u; use_rd = 1'b1;
      end
      OP_JAL: begin
        dec.imm = imm_j; dec.alu_a = in_pc; use_rd = 1'b1;
      end
      OP_JALR: begin
        dec.imm = imm_i; dec.alu_a = in_pc; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm = imm_b; dec.alu_a = reg_rdata1; dec.alu_b = reg_rdata2;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (in_inst[14:12])
          3'b100, 3'b101: dec.alu_funct = 3'b010;
          3'b110, 3'b111: dec.alu_funct = 3'b011;
          default:        dec.alu_funct = 3'b100;
        endcase
      end
      OP_LOAD: begin
        dec.imm = imm_i; dec.alu_a = reg_rdata1; dec.alu_b = imm_i;
        use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_STORE: begin
        dec.imm = imm_s; dec.alu_a = reg_rdata1; dec.alu_b = imm_s;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_CALRI: begin
        dec.imm = imm_i; dec.alu_a = reg_rdata1; dec.alu_b = imm_i;
        dec.alu_funct = in_inst[14:12];
        dec.alu_funcs = in_inst[30] & (in_inst[14:12] == 3'b101);
        use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_CALRR: begin
        dec.alu_a = reg_rdata1; dec.alu_b = reg_rdata2;
        dec.alu_funct = in_inst[14:12];
        dec.alu_funcs = in_inst[30];
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_SYSTEM: begin
        dec.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      default: op_known = 1'b0;
    endcase
    // RV32E only has x0..x15, so bit 4 of any register field in use is out of range
    if (NR_REG == 16) begin
      bad_reg = (use_rd & in_inst[11]) | (use_rs1 & in_inst[19]) | (use_rs2 & in_inst[24]);
    end
    dec.illegal = (in_inst[1:0] != 2'b11) | ~op_known | bad_reg;
    if (dec.illegal) begin
      dec.alu_funct = 3'b000;
      dec.alu_funcs = 1'b0;
    end
  end

`ifdef YSYX_23060203_IDU_SKID_EN
  dec_t skid_q, skid_d;
  logic skid_vld_q, skid_vld_d;
  logic in_rdy_q, in_rdy_d;

  assign in_ready = in_rdy_q;
  assign accept   = in_valid & in_rdy_q & ~flush;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (~out_vld_q | out_ready) begin
      // in_ready is low whenever the skid is full, so skid drain and accept never collide
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
    in_rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end
`else
  assign in_ready = ~out_vld_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (flush) begin
      out_vld_d = 1'b0;
    end else if (accept) begin
      out_d     = dec;
      out_vld_d = 1'b1;
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out_valid     = out_vld_q;
  assign out_pc        = out_q.pc;
  assign out_opcode    = out_q.opcode;
  assign out_funct     = out_q.funct;
  assign out_rd        = out_q.rd;
  assign out_csr       = out_q.csr;
  assign out_src1      = out_q.src1;
  assign out_src2      = out_q.src2;
  assign out_imm       = out_q.imm;
  assign out_alu_a     = out_q.alu_a;
  assign out_alu_b     = out_q.alu_b;
  assign out_alu_funct = out_q.alu_funct;
  assign out_alu_funcs = out_q.alu_funcs;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_ysyx_23060203_idu_stage.sv
// Directed bench for ysyx_23060203_idu_stage: RV32I instance plus an RV32E instance sharing stimulus.
module tb_ysyx_23060203_idu_stage;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc, reg_rdata1, reg_rdata2;

  logic        in_ready, out_valid, out_alu_funcs, out_illegal;
  logic [4:0]  reg_raddr1, reg_raddr2, out_opcode, out_rd;
  logic [2:0]  out_funct, out_alu_funct;
  logic [11:0] out_csr;
  logic [31:0] out_pc, out_src1, out_src2, out_imm, out_alu_a, out_alu_b;

  logic        e_in_ready, e_out_valid, e_alu_funcs, e_illegal;
  logic [3:0]  e_raddr1, e_raddr2;
  logic [4:0]  e_opcode, e_rd;
  logic [2:0]  e_funct, e_alu_funct;
  logic [11:0] e_csr;
  logic [31:0] e_pc, e_src1, e_src2, e_imm, e_alu_a, e_alu_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060203_idu_stage #(.NR_REG(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
    .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode), .out_funct(out_funct),
    .out_rd(out_rd), .out_csr(out_csr), .out_src1(out_src1), .out_src2(out_src2),
    .out_imm(out_imm), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
    .out_alu_funct(out_alu_funct), .out_alu_funcs(out_alu_funcs), .out_illegal(out_illegal)
  );

  ysyx_23060203_idu_stage #(.NR_REG(16)) dut_e (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .reg_raddr1(e_raddr1), .reg_raddr2(e_raddr2),
    .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2), .out_valid(e_out_valid),
    .out_ready(out_ready), .out_pc(e_pc), .out_opcode(e_opcode), .out_funct(e_funct),
    .out_rd(e_rd), .out_csr(e_csr), .out_src1(e_src1), .out_src2(e_src2),
    .out_imm(e_imm), .out_alu_a(e_alu_a), .out_alu_b(e_alu_b),
    .out_alu_funct(e_alu_funct), .out_alu_funcs(e_alu_funcs), .out_illegal(e_illegal)
  );

  task automatic present(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    in_valid   = 1'b1;
    in_inst    = inst;
    in_pc      = pc;
    reg_rdata1 = r1;
    reg_rdata2 = r2;
    out_ready  = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if ({out_pc, out_imm, out_alu_b, out_src1} !== 128'd0) begin n_bad++; $display("FAIL reset_payload got %h want 0", {out_pc, out_imm, out_alu_b, out_src1}); end
    n_cmp++; if (e_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid_e got %b want 0", e_out_valid); end
    @(negedge clk);
    rstn = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    present(32'h00510093, 32'h0000_1000, 32'd7, 32'd0);
    #1;
    n_cmp++; if (reg_raddr1 !== 5'd2 || reg_raddr2 !== 5'd5) begin n_bad++; $display("FAIL addi_raddr got %0d/%0d want 2/5", reg_raddr1, reg_raddr2); end
    n_cmp++; if (e_raddr1 !== 4'd2) begin n_bad++; $display("FAIL addi_raddr_e got %0d want 2", e_raddr1); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid got %b want 1", out_valid); end
    n_cmp++; if (out_imm !== 32'd5 || out_alu_a !== 32'd7 || out_alu_b !== 32'd5) begin n_bad++; $display("FAIL addi_ops got imm=%h a=%h b=%h want 5/7/5", out_imm, out_alu_a, out_alu_b); end
    n_cmp++; if (out_alu_funct !== 3'b000 || out_alu_funcs !== 1'b0 || out_rd !== 5'd1 || out_illegal !== 1'b0) begin n_bad++; $display("FAIL addi_ctl got f=%b s=%b rd=%0d ill=%b want 000/0/1/0", out_alu_funct, out_alu_funcs, out_rd, out_illegal); end
    n_cmp++; if (out_pc !== 32'h0000_1000 || out_opcode !== 5'b00100) begin n_bad++; $display("FAIL addi_pc got %h/%b want 00001000/00100", out_pc, out_opcode); end
    n_cmp++; if (e_illegal !== 1'b0) begin n_bad++; $display("FAIL addi_e_illegal got %b want 0", e_illegal); end
  endtask

  task automatic test_srai();
    present(32'h40225193, 32'h0000_1004, 32'h8000_0000, 32'd0);
    step();
    n_cmp++; if (out_alu_funct !== 3'b101 || out_alu_funcs !== 1'b1) begin n_bad++; $display("FAIL srai_funct got %b/%b want 101/1", out_alu_funct, out_alu_funcs); end
    n_cmp++; if (out_alu_b !== 32'h0000_0402 || out_rd !== 5'd3) begin n_bad++; $display("FAIL srai_b got %h rd=%0d want 00000402 rd=3", out_alu_b, out_rd); end
  endtask

  task automatic test_jal_blt();
    present(32'h008000EF, 32'h8000_0000, 32'h55, 32'h66);
    step();
    n_cmp++; if (out_alu_a !== 32'h8000_0000 || out_alu_b !== 32'd4 || out_alu_funct !== 3'b000) begin n_bad++; $display("FAIL jal_ops got a=%h b=%h f=%b want 80000000/4/000", out_alu_a, out_alu_b, out_alu_funct); end
    n_cmp++; if (out_imm !== 32'd8) begin n_bad++; $display("FAIL jal_imm got %h want 8", out_imm); end
    present(32'h0020C463, 32'h8000_0004, 32'h11, 32'h1234);
    step();
    n_cmp++; if (out_alu_funct !== 3'b010 || out_alu_b !== 32'h1234 || out_alu_a !== 32'h11) begin n_bad++; $display("FAIL blt_ops got f=%b a=%h b=%h want 010/11/1234", out_alu_funct, out_alu_a, out_alu_b); end
    n_cmp++; if (out_imm !== 32'd8 || out_src2 !== 32'h1234) begin n_bad++; $display("FAIL blt_imm got imm=%h src2=%h want 8/1234", out_imm, out_src2); end
  endtask

  task automatic test_illegal();
    present(32'h00208833, 32'h0000_2000, 32'h3, 32'h4);
    step();
    n_cmp++; if (e_illegal !== 1'b1 || e_alu_funct !== 3'b000) begin n_bad++; $display("FAIL rv32e_x16 got ill=%b f=%b want 1/000", e_illegal, e_alu_funct); end
    n_cmp++; if (out_illegal !== 1'b0 || out_alu_a !== 32'h3 || out_alu_b !== 32'h4) begin n_bad++; $display("FAIL rv32i_x16 got ill=%b a=%h b=%h want 0/3/4", out_illegal, out_alu_a, out_alu_b); end
    present(32'h00000000, 32'h0000_2004, 32'h0, 32'h0);
    step();
    n_cmp++; if (out_illegal !== 1'b1 || e_illegal !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL zero_inst got ill=%b/%b vld=%b want 1/1/1", out_illegal, e_illegal, out_valid); end
    present(32'h40225192, 32'h0000_2008, 32'h0, 32'h0);
    step();
    n_cmp++; if (out_illegal !== 1'b1 || out_alu_funct !== 3'b000 || out_alu_funcs !== 1'b0) begin n_bad++; $display("FAIL bad_low_bits got ill=%b f=%b s=%b want 1/000/0", out_illegal, out_alu_funct, out_alu_funcs); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] exp_q[$];
    logic [95:0] got, want, held;
    logic [3:0]  pat;
    int          sent, rcvd;
    logic        acc, prev_stall, prev_fill;
    pat = 4'b1001;
    sent = 0; rcvd = 0; prev_stall = 1'b0; prev_fill = 1'b0; held = '0;
    idle();
    for (int cyc = 0; cyc < 80 && rcvd < 8; cyc++) begin
      @(negedge clk);
      out_ready  = pat[cyc % 4];
      in_valid   = (sent < 8);
      in_inst    = {12'(sent * 3 + 1), 5'd1, 3'b000, 5'(sent + 1), 7'h13};
      in_pc      = 32'h200 + 32'(sent * 4);
      reg_rdata1 = 32'h1000 + 32'(sent);
      #1;
      got = {out_pc, out_imm, out_src1};
      if (prev_stall) begin
        n_cmp++; if (out_valid !== 1'b1 || got !== held) begin n_bad++; $display("FAIL b2b_stable got vld=%b %h want 1 %h", out_valid, got, held); end
      end
`ifdef YSYX_23060203_IDU_SKID_EN
      if (prev_fill) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_in_ready got %b want 0", in_ready); end
      end
`else
      n_cmp++; if (in_ready !== (~out_valid | out_ready)) begin n_bad++; $display("FAIL b2b_in_ready got %b want %b", in_ready, ~out_valid | out_ready); end
`endif
      if (out_valid && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 96'hx;
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL b2b_order got %h want %h", got, want); end
        rcvd++;
      end
      acc        = in_valid && in_ready;
      prev_stall = out_valid && !out_ready;
      prev_fill  = acc && out_valid && !out_ready;
      held       = got;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back({in_pc, 32'(sent * 3 + 1), reg_rdata1});
        sent++;
      end
    end
    n_cmp++; if (rcvd !== 8 || exp_q.size() !== 0) begin n_bad++; $display("FAIL b2b_count got %0d left %0d want 8/0", rcvd, exp_q.size()); end
    idle();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_dup got vld=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    present(32'h00510093, 32'h0000_3000, 32'd1, 32'd2);
    out_ready = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_setup got %b want 1", out_valid); end
    @(negedge clk);
    flush = 1'b1; in_inst = 32'h00A00113; in_pc = 32'h0000_3004;
    step();
    n_cmp++; if (out_valid !== 1'b0 || e_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_clear got %b/%b want 0/0", out_valid, e_out_valid); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_after got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    present(32'h00A00113, 32'h0000_3008, 32'd1, 32'd2);
    flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_idle_rdy got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_drop got %b want 0", out_valid); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    present(32'h40225193, 32'h0000_4000, 32'h9, 32'h9);
    out_ready = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_setup got %b want 1", out_valid); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || {out_pc, out_imm, out_src1, out_alu_b} !== 128'd0) begin n_bad++; $display("FAIL rst_mid_clear got vld=%b %h want 0", out_valid, {out_pc, out_imm, out_src1, out_alu_b}); end
    n_cmp++; if ({out_rd, out_alu_funct, out_alu_funcs, out_illegal} !== 10'd0) begin n_bad++; $display("FAIL rst_mid_ctl got %h want 0", {out_rd, out_alu_funct, out_alu_funcs, out_illegal}); end
    @(negedge clk);
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_after got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0; reg_rdata1 = '0; reg_rdata2 = '0;
    test_reset();
    test_addi();
    test_srai();
    test_jal_blt();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
